// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial pattern detector with a runtime-loadable PAT_W-bit pattern. Qualified input bits
//   shift into a history register. A detection fires when the completing sample fills the
//   history and the history matches the pattern. Detection can overlap or not, and a
//   saturating counter tracks the number of matches.
//
//   Optional feature: define SEQ_DET_MASK_EN to add pat_mask_value. The mask is latched
//   together with the pattern, and a mask bit of 0 marks that bit as don't-care.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   in_valid       in_bit is sampled this cycle
//   in_bit         serial data bit
//   pat_load       latch pat_value (and pat_mask_value) as the new pattern
//   pat_value      new pattern; MSB is the first bit expected in time
//   pat_mask_value compare mask, only present with SEQ_DET_MASK_EN
//   overlap_en     1 = overlapping detection, 0 = non-overlapping
//   count_clr      clear match_count
//   match          one-cycle pulse, one clock after the completing sample
//   match_count    saturating detection count
//   fill_level     number of valid history bits (0..PAT_W)

module seq_detector_param #(
    parameter int unsigned      PAT_W     = 3,
    parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(3'b110),
    parameter int unsigned      CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_bit,
    input  logic                       pat_load,
    input  logic [PAT_W-1:0]           pat_value,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0]           pat_mask_value,
`endif
    input  logic                       overlap_en,
    input  logic                       count_clr,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(PAT_W+1)-1:0] fill_level
);

    localparam int unsigned FillW = $clog2(PAT_W + 1);
    localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);
    // The completing sample is the PAT_W-th, so PAT_W-1 bits must already be held.
    localparam logic [FillW-1:0] FillArm  = FillW'(PAT_W - 1);

    logic [PAT_W-1:0] pattern_q;
    logic [PAT_W-1:0] hist_q;
    logic [FillW-1:0] fill_q;
    logic [CNT_W-1:0] count_q;
    logic             match_q;

    logic [PAT_W-1:0] next_hist;
    logic [PAT_W-1:0] cmp_mask;
    logic             accept;
    logic             hit;
    logic             det;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] mask_q;
    assign cmp_mask = mask_q;
`else
    assign cmp_mask = '1;
`endif

    // A pattern load has priority over a sample in the same cycle; that sample is dropped.
    assign accept    = in_valid & ~pat_load;
    assign next_hist = {hist_q[PAT_W-2:0], in_bit};
    assign hit       = ((next_hist ^ pattern_q) & cmp_mask) == '0;
    assign det       = accept && (fill_q >= FillArm) && hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= PAT_RESET;
            hist_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            match_q <= det;

            if (pat_load) begin
                pattern_q <= pat_value;
                hist_q    <= '0;
                fill_q    <= '0;
`ifdef SEQ_DET_MASK_EN
                mask_q    <= pat_mask_value;
`endif
            end else if (in_valid) begin
                hist_q <= next_hist;
                // Non-overlapping mode restarts the fill, so the next match needs PAT_W
                // fresh samples. The stale history is harmless.
                if (det && !overlap_en) begin
                    fill_q <= '0;
                end else if (fill_q != FillFull) begin
                    fill_q <= fill_q + FillW'(1);
                end
            end

            // Clear then count: a clear coinciding with a detection leaves the count at 1.
            if (count_clr) begin
                count_q <= det ? CNT_W'(1) : '0;
            end else if (det && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign fill_level  = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       pat_load;
    logic [2:0] pat_value;
    logic [2:0] pat_mask_value;
    logic       overlap_en;
    logic       count_clr;
    logic       match;
    logic [7:0] match_count;
    logic [1:0] fill_level;
    logic       match2;
    logic [1:0] count2;
    logic [1:0] fill2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit done     = 1'b0;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;
    exp_t sb_q[$];

    seq_detector_param #(.PAT_W(3), .PAT_RESET(3'b110), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .pat_load   (pat_load),
        .pat_value  (pat_value),
`ifdef SEQ_DET_MASK_EN
        .pat_mask_value(pat_mask_value),
`endif
        .overlap_en (overlap_en),
        .count_clr  (count_clr),
        .match      (match),
        .match_count(match_count),
        .fill_level (fill_level)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    seq_detector_param #(.PAT_W(3), .PAT_RESET(3'b110), .CNT_W(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .pat_load   (pat_load),
        .pat_value  (pat_value),
`ifdef SEQ_DET_MASK_EN
        .pat_mask_value(pat_mask_value),
`endif
        .overlap_en (overlap_en),
        .count_clr  (count_clr),
        .match      (match2),
        .match_count(count2),
        .fill_level (fill2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every match pulse must line up with the next scheduled detection.
    always @(negedge clk) begin
        if (!done) begin
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_match: no pulse at cycle %0d, expected count %0d",
                         sb_q[0].cyc, sb_q[0].cnt);
                void'(sb_q.pop_front());
            end
            if (match) begin
                checks++;
                if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
                    failures++;
                    $display("FAIL unexpected_match: pulse at cycle %0d, none scheduled", cyc);
                end else begin
                    if (int'(match_count) != sb_q[0].cnt) begin
                        failures++;
                        $display("FAIL match_count_at_pulse: got %0d, expected %0d",
                                 match_count, sb_q[0].cnt);
                    end
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; det/cnt give the hand-computed detection outcome.
    task automatic step(input logic v, input logic b, input bit det, input int cnt);
        exp_t e;
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        if (det) begin
            e.cyc = cyc;
            e.cnt = cnt;
            sb_q.push_back(e);
        end
        reset     = 1'b0;
        pat_load  = 1'b0;
        count_clr = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic load(input logic [2:0] pat, input logic [2:0] msk, input logic ovl);
        pat_value      = pat;
        pat_mask_value = msk;
        overlap_en     = ovl;
        pat_load       = 1'b1;
        count_clr      = 1'b1;
        step(1'b1, 1'b1, 1'b0, 0);   // sample dropped by the load
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_bit         = 1'b0;
        pat_load       = 1'b0;
        pat_value      = 3'b000;
        pat_mask_value = 3'b111;
        overlap_en     = 1'b1;
        count_clr      = 1'b0;
        step(1'b0, 1'b0, 1'b0, 0);
        chk("reset_match", int'(match), 0);
        chk("reset_count", int'(match_count), 0);
        chk("reset_fill", int'(fill_level), 0);

        // 1: default pattern 110
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        chk("fill_two", int'(fill_level), 2);
        step(1'b1, 1'b0, 1'b1, 1);
        chk("fill_full", int'(fill_level), 3);

        // 2: pattern 101, overlapping
        load(3'b101, 3'b111, 1'b1);
        chk("load_drops_sample", int'(fill_level), 0);
        chk("load_clr_count", int'(match_count), 0);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 2);
        chk("overlap_count", int'(match_count), 2);

        // 2b: pattern 101, non-overlapping
        load(3'b101, 3'b111, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1);
        chk("nonoverlap_fill_reset", int'(fill_level), 0);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        chk("nonoverlap_fill", int'(fill_level), 2);
        chk("nonoverlap_count", int'(match_count), 1);

        // 3: gaps hold history and fill
        load(3'b110, 3'b111, 1'b1);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        chk("gap_fill_hold", int'(fill_level), 1);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        chk("gap_fill_two", int'(fill_level), 2);
        step(1'b1, 1'b0, 1'b1, 1);

        // 4: reset mid-sequence
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 0);
        chk("midreset_fill", int'(fill_level), 0);
        chk("midreset_count", int'(match_count), 0);
        step(1'b1, 1'b0, 1'b0, 0);
        chk("post_reset_fill", int'(fill_level), 1);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 1);   // proves pattern is back to 110

        // 5: pattern 111, seven ones, saturation on the 2-bit instance
        load(3'b111, 3'b111, 1'b1);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 1'b1, i);
        chk("count_five", int'(match_count), 5);
        chk("sat_count", int'(count2), 3);
        count_clr = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1);
        chk("clr_on_det", int'(match_count), 1);
        chk("clr_on_det_narrow", int'(count2), 1);
        overlap_en = 1'b0;
        step(1'b1, 1'b1, 1'b1, 2);
        overlap_en = 1'b1;
        step(1'b1, 1'b1, 1'b0, 0);
        chk("overlap_switch_fill", int'(fill_level), 1);

`ifdef SEQ_DET_MASK_EN
        // 6: pattern 100 with middle bit don't-care
        load(3'b100, 3'b101, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 1);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 2);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        chk("mask_count", int'(match_count), 2);
`endif

        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        done = 1'b1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
